role_axi_lite_ctrl_regs: RTL and testbench
==========================================

# role_axi_lite_ctrl_regs

AXI4-Lite responder in the role region that terminates the shell's AXI-Lite control master. It carries the control/status/argument register map for the HLS kernel in the PR region. It converts host register accesses into ap_start/argument outputs and collects kernel handshake status into sticky, readable and interrupt-generating bits. Single clock domain, the 250 MHz role clock.

## Interface
Parameters:
- ADDR_W, 12: AXI-Lite address width (byte address).
- NUM_ARGS, 4: number of 32-bit kernel argument registers (1..16).
- VERSION, 32'h0001_0000: value of the read-only version register.

Ports:
- CLK_IN_250  in  1  sole clock; all logic rising-edge.
- AXI_RESET_N  in  1  reset, synchronous, active-low.
- S_AWADDR / S_AWVALID / S_AWREADY  in/in/out  ADDR_W/1/1  write address channel.
- S_WDATA / S_WSTRB / S_WVALID / S_WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_BRESP / S_BVALID / S_BREADY  out/out/in  2/1/1  write response.
- S_ARADDR / S_ARVALID / S_ARREADY  in/in/out  ADDR_W/1/1  read address.
- S_RDATA / S_RRESP / S_RVALID / S_RREADY  out/out/out/in  32/2/1/1  read data.
- AP_START  out  1  kernel start level.
- AP_DONE / AP_IDLE / AP_READY  in  1 each  kernel status (DONE, READY are one-cycle pulses).
- ARGS  out  32*NUM_ARGS  argument registers, arg0 in bits [31:0].
- IRQ  out  1  level interrupt.

## Operation
Register map (word-aligned; ADDR[1:0] ignored):
- 0x00 CTRL: b0 ap_start (RW, W1 sets; writing 0 has no effect; self-clears on AP_READY unless b7 set); b1 done (RO, sticky, clear-on-read); b2 idle (RO, live AP_IDLE); b3 ready (RO, sticky, clear-on-read); b7 auto_restart (RW).
- 0x04 GIE: b0 global interrupt enable.
- 0x08 IER: b0 done enable, b1 ready enable.
- 0x0C ISR: b0 done, b1 ready; set by event; a 1 written toggles the bit.
- 0x10 SCRATCH: RW, 32 bits.
- 0x14 VERSION: RO.
- 0x20 + 4*i: ARG i, RW, for i < NUM_ARGS.
- Any other offset: read returns 0 with RRESP=SLVERR (2'b10); write is discarded with BRESP=SLVERR. Mapped accesses return OKAY. Writes to RO bits are ignored with OKAY.
- WSTRB byte-masks every RW register. Single-bit registers use strobe lane 0 only.
- IRQ = GIE & |(IER & ISR), registered.

Write path:
- AW and W are accepted independently, in either order or in the same cycle.
- S_AWREADY = !aw_held & !S_BVALID. S_WREADY = !w_held & !S_BVALID.
- The register update and S_BVALID rise in the cycle after both are held.
- S_BVALID holds until S_BREADY. No new AW/W is accepted while S_BVALID is high.

Read path:
- S_ARREADY = !S_RVALID.
- S_RDATA/S_RRESP/S_RVALID are registered the cycle after the AR handshake and held stable until S_RREADY.
- Clear-on-read side effects apply in the AR-handshake cycle.

Simultaneous events:
- AP_DONE/AP_READY pulse in the same cycle as a clearing CTRL read: the read returns the pre-clear value, and the bit ends at 1.
- ISR toggle write coincident with an event: the event wins, and the bit ends at 1.
- Host W1 to ap_start coincident with AP_READY: the host wins, and ap_start ends at 1.
- A read and a write arriving in the same cycle proceed independently. The read returns the pre-write value.

## Timing
- Reset (AXI_RESET_N=0 at a clock edge) values: all READY outputs 0 during reset, then AWREADY/WREADY/ARREADY=1 in the first cycle after release. BVALID=0, RVALID=0, BRESP=RRESP=0, RDATA=0. AP_START=0, ARGS=0, IRQ=0. All registers 0 except VERSION.
- Reset mid-transaction drops any held AW/W/AR and pending response. No response is issued for them.
- Write latency: BVALID rises 1 cycle after the later of the AW/W handshakes. Read latency: RVALID rises 1 cycle after the AR handshake.
- AP_START reflects a register write at the same edge BVALID rises.
- IRQ lags the ISR change by 1 cycle.
- Back-to-back throughput: one write per 2 cycles with BREADY tied 1; one read per 2 cycles with RREADY tied 1.

## Structure
- Package role_ctrl_pkg holds:
  - offset localparams (CTRL, GIE, IER, ISR, SCRATCH, VERSION, ARG_BASE);
  - resp codes (RESP_OKAY=2'b00, RESP_SLVERR=2'b10);
  - a CTRL bit-index enum.
- Sub-module role_axil_rsp_chan implements the AW/W hold, B, AR and R handshake logic. It emits a one-cycle wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr, and accepts rd_data/rd_err and wr_err.
- The top module holds the register map, the sticky logic and IRQ.

## Test plan
- W first, then AW 3 cycles later, to 0x10 with data 0xA5A5_1234 and WSTRB=4'b0011: BVALID 1 cycle after the AW handshake, BRESP=0. A read of 0x10 returns 0x0000_1234 with RVALID 1 cycle after AR.
- Write 0x01 to CTRL: AP_START=1. AP_READY pulse → AP_START=0. Repeat with auto_restart set (0x81): AP_START stays 1.
- GIE=1, IER=1, AP_DONE pulse: CTRL read returns b1=1 and a second read returns b1=0. IRQ=1 two cycles after the pulse. Writing ISR=1 clears IRQ 1 cycle later.
- AP_DONE pulse in the same cycle as a CTRL AR handshake: RDATA b1 reflects the pre-pulse value, and the next read returns b1=1.
- Read 0x40 (NUM_ARGS=4) → RDATA=0, RRESP=2'b10. Write 0x40 → BRESP=2'b10, and no register changes.
- Assert AXI_RESET_N=0 while BVALID is held with BREADY=0: after release BVALID=0, all READYs=1, ARGS=0, AP_START=0.

Source files
------------

// File: rtl/role_axi_lite_ctrl_regs_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// role_ctrl_pkg : register offsets, response codes and CTRL bit layout
// Rev 1.0
// ----------------------------------------------------------------------------
package role_ctrl_pkg;

  localparam logic [31:0] CTRL_OFF     = 32'h00;
  localparam logic [31:0] GIE_OFF      = 32'h04;
  localparam logic [31:0] IER_OFF      = 32'h08;
  localparam logic [31:0] ISR_OFF      = 32'h0C;
  localparam logic [31:0] SCRATCH_OFF  = 32'h10;
  localparam logic [31:0] VERSION_OFF  = 32'h14;
  localparam logic [31:0] ARG_BASE_OFF = 32'h20;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [4:0] {
    CTRL_START = 5'd0,
    CTRL_DONE  = 5'd1,
    CTRL_IDLE  = 5'd2,
    CTRL_READY = 5'd3,
    CTRL_AUTO  = 5'd7
  } ctrl_bit_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? wdat[8*b +: 8] : cur[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/role_axi_lite_ctrl_regs_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// role_axi_lite_ctrl_regs_if : AXI4-Lite control bus bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface role_axi_lite_ctrl_regs_if #(
  parameter int ADDR_W = 12
) ();
  logic [ADDR_W-1:0] S_AWADDR;
  logic              S_AWVALID;
  logic              S_AWREADY;
  logic [31:0]       S_WDATA;
  logic [3:0]        S_WSTRB;
  logic              S_WVALID;
  logic              S_WREADY;
  logic [1:0]        S_BRESP;
  logic              S_BVALID;
  logic              S_BREADY;
  logic [ADDR_W-1:0] S_ARADDR;
  logic              S_ARVALID;
  logic              S_ARREADY;
  logic [31:0]       S_RDATA;
  logic [1:0]        S_RRESP;
  logic              S_RVALID;
  logic              S_RREADY;

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY,
           S_RDATA, S_RRESP, S_RVALID
  );

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY,
           S_RDATA, S_RRESP, S_RVALID
  );
endinterface
`default_nettype wire

// File: rtl/role_axi_lite_ctrl_regs_rsp_chan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// role_axil_rsp_chan : AXI-Lite AW/W hold, B and AR/R handshake engine
// Rev 1.0
// ----------------------------------------------------------------------------
module role_axil_rsp_chan
  import role_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  role_axi_lite_ctrl_regs_if.slave bus,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic              rd_err
);

  logic              r_live;
  logic              r_aw_held;
  logic              r_w_held;
  logic [ADDR_W-1:0] r_awaddr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic              r_rvalid;
  logic [1:0]        r_rresp;
  logic [31:0]       r_rdata;

  logic w_aw_rdy, w_w_rdy, w_ar_rdy;
  logic w_aw_hs, w_w_hs, w_ar_hs;

  // r_live keeps every READY low while reset is asserted
  assign w_aw_rdy = r_live & ~r_aw_held & ~r_bvalid;
  assign w_w_rdy  = r_live & ~r_w_held  & ~r_bvalid;
  assign w_ar_rdy = r_live & ~r_rvalid;

  assign w_aw_hs = bus.S_AWVALID & w_aw_rdy;
  assign w_w_hs  = bus.S_WVALID  & w_w_rdy;
  assign w_ar_hs = bus.S_ARVALID & w_ar_rdy;

  // A write commits on the edge where the later of AW/W arrives
  assign wr_en   = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
  assign wr_addr = r_aw_held ? r_awaddr : bus.S_AWADDR;
  assign wr_data = r_w_held  ? r_wdata  : bus.S_WDATA;
  assign wr_strb = r_w_held  ? r_wstrb  : bus.S_WSTRB;

  assign rd_en   = w_ar_hs;
  assign rd_addr = bus.S_ARADDR;

  assign bus.S_AWREADY = w_aw_rdy;
  assign bus.S_WREADY  = w_w_rdy;
  assign bus.S_BVALID  = r_bvalid;
  assign bus.S_BRESP   = r_bresp;
  assign bus.S_ARREADY = w_ar_rdy;
  assign bus.S_RVALID  = r_rvalid;
  assign bus.S_RRESP   = r_rresp;
  assign bus.S_RDATA   = r_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_live    <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_live <= 1'b1;

      if (wr_en) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= bus.S_AWADDR;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= bus.S_WDATA;
          r_wstrb  <= bus.S_WSTRB;
        end
        if (r_bvalid && bus.S_BREADY) begin
          r_bvalid <= 1'b0;
        end
      end

      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= rd_data;
        r_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_rvalid && bus.S_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/role_axi_lite_ctrl_regs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// role_axi_lite_ctrl_regs : HLS kernel control/status/argument register map
// Rev 1.0
// ----------------------------------------------------------------------------
module role_axi_lite_ctrl_regs
  import role_ctrl_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter int          NUM_ARGS = 4,
  parameter logic [31:0] VERSION  = 32'h0001_0000
) (
  input  logic                    CLK_IN_250,
  input  logic                    AXI_RESET_N,
  role_axi_lite_ctrl_regs_if.slave s_axil,
  output logic                    AP_START,
  input  logic                    AP_DONE,
  input  logic                    AP_IDLE,
  input  logic                    AP_READY,
  output logic [32*NUM_ARGS-1:0]  ARGS,
  output logic                    IRQ
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              wr_err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_err;

  role_axil_rsp_chan #(
    .ADDR_W (ADDR_W)
  ) u_rsp_chan (
    .clk     (CLK_IN_250),
    .rst_n   (AXI_RESET_N),
    .bus     (s_axil),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_err  (wr_err),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_err  (rd_err)
  );

  logic              r_start, r_done, r_ready, r_auto, r_gie, r_irq;
  logic [1:0]        r_ier, r_isr;
  logic [31:0]       r_scratch;
  logic [31:0]       r_args [NUM_ARGS];

  logic [31:0]         w_wr_off, w_rd_off;
  logic                w_wr_ctrl, w_wr_gie, w_wr_ier, w_wr_isr, w_wr_scr, w_wr_ver;
  logic [NUM_ARGS-1:0] w_wr_arg;
  logic                w_rd_ctrl, w_ctrl_w0;
  logic                w_start_nxt, w_done_nxt, w_ready_nxt;
  logic [1:0]          w_isr_nxt;

  // Byte address with the sub-word bits dropped
  assign w_wr_off = 32'(wr_addr) & ~32'h3;
  assign w_rd_off = 32'(rd_addr) & ~32'h3;

  always_comb begin
    w_wr_ctrl = (w_wr_off == CTRL_OFF);
    w_wr_gie  = (w_wr_off == GIE_OFF);
    w_wr_ier  = (w_wr_off == IER_OFF);
    w_wr_isr  = (w_wr_off == ISR_OFF);
    w_wr_scr  = (w_wr_off == SCRATCH_OFF);
    w_wr_ver  = (w_wr_off == VERSION_OFF);
    w_wr_arg  = '0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (w_wr_off == ARG_BASE_OFF + 32'(4*i)) w_wr_arg[i] = 1'b1;
    end
    wr_err = ~(w_wr_ctrl | w_wr_gie | w_wr_ier | w_wr_isr | w_wr_scr |
               w_wr_ver | (|w_wr_arg));
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (w_rd_off)
      CTRL_OFF: begin
        rd_data[CTRL_START] = r_start;
        rd_data[CTRL_DONE]  = r_done;
        rd_data[CTRL_IDLE]  = AP_IDLE;
        rd_data[CTRL_READY] = r_ready;
        rd_data[CTRL_AUTO]  = r_auto;
      end
      GIE_OFF:     rd_data[0]   = r_gie;
      IER_OFF:     rd_data[1:0] = r_ier;
      ISR_OFF:     rd_data[1:0] = r_isr;
      SCRATCH_OFF: rd_data      = r_scratch;
      VERSION_OFF: rd_data      = VERSION;
      default:     rd_err       = 1'b1;
    endcase
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (w_rd_off == ARG_BASE_OFF + 32'(4*i)) begin
        rd_data = r_args[i];
        rd_err  = 1'b0;
      end
    end
  end

  // Kernel events take priority over host clears/toggles; host W1 beats AP_READY
  always_comb begin
    w_rd_ctrl = rd_en & (w_rd_off == CTRL_OFF);
    w_ctrl_w0 = wr_en & w_wr_ctrl & wr_strb[0];

    w_start_nxt = r_start;
    if (AP_READY && !r_auto) w_start_nxt = 1'b0;
    if (w_ctrl_w0 && wr_data[CTRL_START]) w_start_nxt = 1'b1;

    w_done_nxt  = (r_done  & ~w_rd_ctrl) | AP_DONE;
    w_ready_nxt = (r_ready & ~w_rd_ctrl) | AP_READY;

    w_isr_nxt = r_isr;
    if (wr_en && w_wr_isr && wr_strb[0]) w_isr_nxt = w_isr_nxt ^ wr_data[1:0];
    w_isr_nxt = w_isr_nxt | {AP_READY, AP_DONE};
  end

  always_ff @(posedge CLK_IN_250) begin
    if (!AXI_RESET_N) begin
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b0;
      r_auto    <= 1'b0;
      r_gie     <= 1'b0;
      r_ier     <= '0;
      r_isr     <= '0;
      r_scratch <= '0;
      r_irq     <= 1'b0;
      for (int i = 0; i < NUM_ARGS; i++) r_args[i] <= '0;
    end else begin
      r_start <= w_start_nxt;
      r_done  <= w_done_nxt;
      r_ready <= w_ready_nxt;
      r_isr   <= w_isr_nxt;
      if (w_ctrl_w0) r_auto <= wr_data[CTRL_AUTO];
      if (wr_en && w_wr_gie && wr_strb[0]) r_gie <= wr_data[0];
      if (wr_en && w_wr_ier && wr_strb[0]) r_ier <= wr_data[1:0];
      if (wr_en && w_wr_scr) r_scratch <= strb_merge(r_scratch, wr_data, wr_strb);
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (wr_en && w_wr_arg[i]) r_args[i] <= strb_merge(r_args[i], wr_data, wr_strb);
      end
      r_irq <= r_gie & (|(r_ier & r_isr));
    end
  end

  for (genvar i = 0; i < NUM_ARGS; i++) begin : g_args
    assign ARGS[32*i +: 32] = r_args[i];
  end

  assign AP_START = r_start;
  assign IRQ      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_role_axi_lite_ctrl_regs.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_role_axi_lite_ctrl_regs : randomized bench with a register-map reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_role_axi_lite_ctrl_regs;

  localparam int NUM_ARGS = 4;
  localparam logic [31:0] VER = 32'h0001_0000;

  logic clk;
  logic rst_n;
  logic ap_start, ap_done, ap_idle, ap_ready, irq;
  logic [32*NUM_ARGS-1:0] args;

  role_axi_lite_ctrl_regs_if #(.ADDR_W(12)) bus ();

  role_axi_lite_ctrl_regs #(
    .ADDR_W   (12),
    .NUM_ARGS (NUM_ARGS),
    .VERSION  (VER)
  ) dut (
    .CLK_IN_250  (clk),
    .AXI_RESET_N (rst_n),
    .s_axil      (bus),
    .AP_START    (ap_start),
    .AP_DONE     (ap_done),
    .AP_IDLE     (ap_idle),
    .AP_READY    (ap_ready),
    .ARGS        (args),
    .IRQ         (irq)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: register contents as the host sees them
  logic        m_start, m_done, m_ready, m_auto, m_gie;
  logic [1:0]  m_ier, m_isr;
  logic [31:0] m_scratch;
  logic [31:0] m_args [NUM_ARGS];

  task automatic model_reset();
    m_start = 0; m_done = 0; m_ready = 0; m_auto = 0; m_gie = 0;
    m_ier = 0; m_isr = 0; m_scratch = 0;
    for (int i = 0; i < NUM_ARGS; i++) m_args[i] = 0;
  endtask

  function automatic logic [31:0] bytes_merge(input logic [31:0] cur, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic int arg_index(input logic [11:0] off);
    if (off >= 12'h20 && off < 12'(32 + 4*NUM_ARGS)) return (int'(off) - 32) / 4;
    return -1;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    logic [11:0] off;
    off = a & 12'hFFC;
    resp = 2'b00;
    case (off)
      12'h00: if (s[0]) begin if (d[0]) m_start = 1; m_auto = d[7]; end
      12'h04: if (s[0]) m_gie = d[0];
      12'h08: if (s[0]) m_ier = d[1:0];
      12'h0C: if (s[0]) m_isr = m_isr ^ d[1:0];
      12'h10: m_scratch = bytes_merge(m_scratch, d, s);
      12'h14: ;
      default: begin
        if (arg_index(off) >= 0) m_args[arg_index(off)] = bytes_merge(m_args[arg_index(off)], d, s);
        else resp = 2'b10;
      end
    endcase
  endtask

  task automatic model_read(input logic [11:0] a, input logic idle,
                            output logic [31:0] d, output logic [1:0] resp);
    logic [11:0] off;
    off = a & 12'hFFC;
    d = 0;
    resp = 2'b00;
    case (off)
      12'h00: begin
        d = (32'(m_auto) << 7) | (32'(m_ready) << 3) | (32'(idle) << 2) |
            (32'(m_done) << 1) | 32'(m_start);
        m_done = 0;
        m_ready = 0;
      end
      12'h04: d = 32'(m_gie);
      12'h08: d = 32'(m_ier);
      12'h0C: d = 32'(m_isr);
      12'h10: d = m_scratch;
      12'h14: d = VER;
      default: begin
        if (arg_index(off) >= 0) d = m_args[arg_index(off)];
        else resp = 2'b10;
      end
    endcase
  endtask

  // kev[0] = AP_DONE, kev[1] = AP_READY
  task automatic model_ready_clear(input logic [1:0] kev);
    if (kev[1] && !m_auto) m_start = 0;
  endtask

  task automatic model_sticky(input logic [1:0] kev);
    if (kev[0]) begin m_done = 1; m_isr[0] = 1; end
    if (kev[1]) begin m_ready = 1; m_isr[1] = 1; end
  endtask

  function automatic logic model_irq();
    return m_gie && ((m_ier & m_isr) != 0);
  endfunction

  task automatic check_outputs();
    check_eq("ap_start", ap_start, m_start);
    check_eq("irq", irq, model_irq());
    for (int i = 0; i < NUM_ARGS; i++) check_eq("args", args[32*i +: 32], m_args[i]);
  endtask

  // aw_dly > 0: AW trails W by that many cycles; < 0: W trails AW
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input logic [1:0] kev);
    int aw_wait, w_wait, n;
    bit aw_done, w_done, aw_go, w_go;
    logic [1:0] exp_resp;
    aw_wait = (aw_dly > 0) ? aw_dly : 0;
    w_wait  = (aw_dly < 0) ? -aw_dly : 0;
    aw_done = 0; w_done = 0; n = 0;
    bus.S_AWADDR = a; bus.S_WDATA = d; bus.S_WSTRB = s;
    while (!(aw_done && w_done) && n < 40) begin
      bus.S_AWVALID = !aw_done && (aw_wait == 0);
      bus.S_WVALID  = !w_done && (w_wait == 0);
      aw_go = bus.S_AWVALID && bus.S_AWREADY;
      w_go  = bus.S_WVALID && bus.S_WREADY;
      if ((aw_go || aw_done) && (w_go || w_done)) begin
        ap_done = kev[0]; ap_ready = kev[1];
      end
      @(posedge clk); #1;
      ap_done = 0; ap_ready = 0;
      if (aw_go) aw_done = 1;
      if (w_go) w_done = 1;
      if (aw_wait > 0) aw_wait--;
      if (w_wait > 0) w_wait--;
      n++;
      if (!(aw_done && w_done)) check_eq("b_early", bus.S_BVALID, 0);
    end
    bus.S_AWVALID = 0; bus.S_WVALID = 0;
    if (!(aw_done && w_done)) check_eq("wr_timeout", 0, 1);
    model_ready_clear(kev);
    model_write(a, d, s, exp_resp);
    model_sticky(kev);
    check_eq("b_latency", bus.S_BVALID, 1);
    check_eq("bresp", bus.S_BRESP, exp_resp);
    check_eq("start_at_b", ap_start, m_start);
    @(posedge clk); #1;
    check_eq("b_clear", bus.S_BVALID, 0);
  endtask

  task automatic axi_read(input logic [11:0] a, input logic idle, input logic [1:0] kev);
    int n;
    bit go;
    logic [31:0] exp_d;
    logic [1:0] exp_r;
    bus.S_ARADDR = a; bus.S_ARVALID = 1; ap_idle = idle;
    n = 0; go = 0;
    while (!go && n < 40) begin
      go = bus.S_ARREADY;
      if (go) begin ap_done = kev[0]; ap_ready = kev[1]; end
      @(posedge clk); #1;
      ap_done = 0; ap_ready = 0;
      n++;
    end
    bus.S_ARVALID = 0;
    if (!go) check_eq("rd_timeout", 0, 1);
    model_read(a, idle, exp_d, exp_r);
    model_ready_clear(kev);
    model_sticky(kev);
    check_eq("r_latency", bus.S_RVALID, 1);
    check_eq("rdata", bus.S_RDATA, exp_d);
    check_eq("rresp", bus.S_RRESP, exp_r);
    @(posedge clk); #1;
    check_eq("r_clear", bus.S_RVALID, 0);
  endtask

  task automatic kernel_pulse(input logic [1:0] kev);
    ap_done = kev[0]; ap_ready = kev[1];
    @(posedge clk); #1;
    ap_done = 0; ap_ready = 0;
    model_ready_clear(kev);
    model_sticky(kev);
    @(posedge clk); #1;
  endtask

  logic [11:0] picks [15] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                              12'h018, 12'h01C, 12'h020, 12'h024, 12'h028, 12'h02C,
                              12'h030, 12'h040, 12'hFFC};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    ap_done = 0; ap_idle = 0; ap_ready = 0;
    bus.S_AWADDR = 0; bus.S_AWVALID = 0; bus.S_WDATA = 0; bus.S_WSTRB = 0;
    bus.S_WVALID = 0; bus.S_BREADY = 1; bus.S_ARADDR = 0; bus.S_ARVALID = 0;
    bus.S_RREADY = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_awready", bus.S_AWREADY, 0);
    check_eq("rst_arready", bus.S_ARREADY, 0);
    rst_n = 1;
    @(posedge clk); #1;
    check_eq("rel_awready", bus.S_AWREADY, 1);
    check_eq("rel_wready", bus.S_WREADY, 1);
    check_eq("rel_arready", bus.S_ARREADY, 1);
    check_eq("rel_bvalid", bus.S_BVALID, 0);
    check_eq("rel_rvalid", bus.S_RVALID, 0);
    check_eq("rel_rdata", bus.S_RDATA, 0);
    check_eq("rel_bresp", bus.S_BRESP, 0);
    check_eq("rel_rresp", bus.S_RRESP, 0);
    check_outputs();
    axi_read(12'h014, 0, 2'b00);

    // W leads AW by three cycles, partial strobe
    axi_write(12'h010, 32'hA5A5_1234, 4'b0011, 3, 2'b00);
    axi_read(12'h010, 0, 2'b00);
    check_eq("scratch_strb", m_scratch, 32'h0000_1234);

    // ap_start self-clear and auto-restart
    axi_write(12'h000, 32'h1, 4'hF, 0, 2'b00);
    check_eq("start_set", ap_start, 1);
    kernel_pulse(2'b10);
    check_eq("start_selfclr", ap_start, 0);
    axi_write(12'h000, 32'h81, 4'hF, -2, 2'b00);
    kernel_pulse(2'b10);
    check_eq("start_auto", ap_start, 1);
    axi_write(12'h000, 32'h0, 4'hF, 0, 2'b00);
    kernel_pulse(2'b10);
    check_eq("start_off", ap_start, 0);
    axi_read(12'h000, 1, 2'b00);

    // interrupt path
    axi_write(12'h004, 32'h1, 4'h1, 0, 2'b00);
    axi_write(12'h008, 32'h1, 4'h1, 1, 2'b00);
    ap_done = 1;
    @(posedge clk); #1;
    ap_done = 0;
    model_sticky(2'b01);
    check_eq("irq_lag", irq, 0);
    @(posedge clk); #1;
    check_eq("irq_set", irq, 1);
    axi_read(12'h000, 0, 2'b00);
    axi_read(12'h000, 0, 2'b00);
    axi_write(12'h00C, 32'h1, 4'h1, 0, 2'b00);
    check_eq("irq_clr", irq, 0);

    // coincident events
    axi_read(12'h000, 0, 2'b01);
    axi_read(12'h000, 0, 2'b00);
    axi_write(12'h00C, 32'h1, 4'h1, 0, 2'b01);
    check_outputs();
    axi_write(12'h000, 32'h1, 4'h1, 0, 2'b10);
    check_outputs();

    // unmapped offsets
    axi_write(12'h020, 32'hDEAD_BEEF, 4'hF, 0, 2'b00);
    axi_read(12'h040, 0, 2'b00);
    axi_write(12'h040, 32'h1234_5678, 4'hF, 0, 2'b00);
    check_outputs();
    for (int i = 0; i < 6; i++) axi_read(picks[i], 0, 2'b00);

    for (int k = 0; k < 300; k++) begin
      int op;
      logic [11:0] a;
      op = $urandom_range(0, 9);
      a = picks[$urandom_range(0, 14)] | 12'($urandom_range(0, 3));
      if (op < 4)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)) - 2,
                  ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
      else if (op < 8)
        axi_read(a, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
      else
        kernel_pulse(2'($urandom_range(1, 3)));
      check_outputs();
    end

    // reset while a response is pending
    axi_write(12'h024, 32'h5555_AAAA, 4'hF, 0, 2'b00);
    axi_write(12'h000, 32'h1, 4'hF, 0, 2'b00);
    bus.S_BREADY = 0;
    bus.S_AWADDR = 12'h020; bus.S_AWVALID = 1;
    bus.S_WDATA = 32'h1111_2222; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1;
    @(posedge clk); #1;
    bus.S_AWVALID = 0; bus.S_WVALID = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("bvalid_held", bus.S_BVALID, 1);
    rst_n = 0;
    @(posedge clk); #1;
    check_eq("mid_rst_wready", bus.S_WREADY, 0);
    rst_n = 1;
    bus.S_BREADY = 1;
    model_reset();
    @(posedge clk); #1;
    check_eq("post_bvalid", bus.S_BVALID, 0);
    check_eq("post_awready", bus.S_AWREADY, 1);
    check_eq("post_wready", bus.S_WREADY, 1);
    check_eq("post_arready", bus.S_ARREADY, 1);
    check_outputs();
    axi_read(12'h020, 0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
